bayer_to_rgb: RTL and testbench



---
 rtl/bayer_to_rgb_pkg.sv | 17 +
 rtl/bayer_line_buffer.sv | 35 +++
 rtl/bayer_to_rgb.sv | 171 +++++++++++++++++
 tb/tb_bayer_to_rgb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_to_rgb_pkg.sv
// Shared constants and types for the GRBG Bayer-to-RGB demosaic path.
package bayer_to_rgb_pkg;

   localparam int unsigned DATA_W_DEF = 10;
   localparam int unsigned Y_W        = 12;

   // Row phases of the GRBG mosaic: even rows carry G/R, odd rows carry B/G
   localparam logic PHASE_ROW_GR = 1'b0;
   localparam logic PHASE_ROW_BG = 1'b1;

   typedef enum logic [1:0] {
      ST_WAIT_GAP   = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_ACTIVE     = 2'd2
   } sync_state_t;

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line sample store: single port, read-before-write, registered read data.
module bayer_line_buffer #(
   parameter int unsigned DEPTH  = 1280,
   parameter int unsigned WIDTH  = 10,
   parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage is intentionally not reset; contents are don't-care until rewritten
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_en) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/bayer_to_rgb.sv
// GRBG Bayer to RGB demosaic using a 2x2 window; two-stage pipeline after accept.
module bayer_to_rgb
   import bayer_to_rgb_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = 1280,
   parameter int unsigned DATA_W     = DATA_W_DEF
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iFVAL,
   input  logic              iDVAL,
   input  logic [DATA_W-1:0] iDATA,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic              oDVAL
);

   localparam int unsigned     X_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [X_W-1:0]  X_LAST = X_W'(LINE_WIDTH - 1);

   sync_state_t       r_state;
   sync_state_t       w_state_next;
   logic              w_accept;

   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;

   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_c;
   logic [DATA_W-1:0] r_d;
   logic              r_x0;
   logic              r_y0;
   logic              r_s1_valid;

   logic [DATA_W-1:0] w_green_ad;
   logic [DATA_W-1:0] w_green_bc;
   logic [DATA_W-1:0] w_red;
   logic [DATA_W-1:0] w_green;
   logic [DATA_W-1:0] w_blue;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state <= ST_WAIT_GAP;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Frame sync: only a full low-then-high iFVAL cycle opens a frame
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         ST_WAIT_GAP: begin
            if (!iFVAL) w_state_next = ST_WAIT_FRAME;
         end
         ST_WAIT_FRAME: begin
            if (iFVAL) w_state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!iFVAL) w_state_next = ST_WAIT_FRAME;
            w_accept = iFVAL & iDVAL;
         end
         default: begin
            w_state_next = ST_WAIT_GAP;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_x <= '0;
         r_y <= '0;
      end else if ((r_state != ST_ACTIVE) || !iFVAL) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_accept) begin
         if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y != '1) r_y <= r_y + Y_W'(1);
         end else begin
            r_x <= r_x + X_W'(1);
         end
      end
   end

   bayer_line_buffer #(
      .DEPTH  (LINE_WIDTH),
      .WIDTH  (DATA_W),
      .ADDR_W (X_W)
   ) u_line_buf (
      .i_clk   (iCLK),
      .i_rst_n (iRST_N),
      .i_en    (w_accept),
      .i_addr  (r_x),
      .i_wdata (iDATA),
      .o_rdata (w_b)
   );

   // Stage 1: b arrives from the line buffer's read register alongside these
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_a        <= '0;
         r_c        <= '0;
         r_d        <= '0;
         r_x0       <= 1'b0;
         r_y0       <= 1'b0;
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept && (r_x != '0) && (r_y != '0);
         if (w_accept) begin
            r_a  <= w_b;
            r_c  <= r_d;
            r_d  <= iDATA;
            r_x0 <= r_x[0];
            r_y0 <= r_y[0];
         end
      end
   end

   assign w_green_ad = DATA_W'(({1'b0, r_a} + {1'b0, r_d}) >> 1);
   assign w_green_bc = DATA_W'(({1'b0, w_b} + {1'b0, r_c}) >> 1);

   // Greens sit on the diagonal matching the current pixel's own site type
   always_comb begin
      w_red   = r_c;
      w_blue  = w_b;
      w_green = w_green_ad;
      case ({r_y0, r_x0})
         {PHASE_ROW_BG, 1'b1}: begin
            w_red   = w_b;
            w_blue  = r_c;
            w_green = w_green_ad;
         end
         {PHASE_ROW_BG, 1'b0}: begin
            w_red   = r_a;
            w_blue  = r_d;
            w_green = w_green_bc;
         end
         {PHASE_ROW_GR, 1'b1}: begin
            w_red   = r_d;
            w_blue  = r_a;
            w_green = w_green_bc;
         end
         default: begin
            w_red   = r_c;
            w_blue  = w_b;
            w_green = w_green_ad;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oRed   <= '0;
         oGreen <= '0;
         oBlue  <= '0;
         oDVAL  <= 1'b0;
      end else begin
         oDVAL <= r_s1_valid;
         if (r_s1_valid) begin
            oRed   <= w_red;
            oGreen <= w_green;
            oBlue  <= w_blue;
         end
      end
   end

endmodule

// File: tb/tb_bayer_to_rgb.sv
// Scoreboard bench for bayer_to_rgb on a 4-pixel-wide line.
module tb_bayer_to_rgb;

   localparam int unsigned LW     = 4;
   localparam int unsigned DATA_W = 10;

   logic              iCLK;
   logic              iRST_N;
   logic              iFVAL;
   logic              iDVAL;
   logic [DATA_W-1:0] iDATA;
   logic [DATA_W-1:0] oRed;
   logic [DATA_W-1:0] oGreen;
   logic [DATA_W-1:0] oBlue;
   logic              oDVAL;

   typedef struct {
      int x;
      int y;
      int r;
      int g;
      int b;
      int due;
   } exp_t;

   exp_t sb[$];
   int   img[0:3][0:LW-1];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   bayer_to_rgb #(.LINE_WIDTH(LW), .DATA_W(DATA_W)) dut (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iFVAL  (iFVAL),
      .iDVAL  (iDVAL),
      .iDATA  (iDATA),
      .oRed   (oRed),
      .oGreen (oGreen),
      .oBlue  (oBlue),
      .oDVAL  (oDVAL)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   always @(posedge iCLK) cyc <= cyc + 1;

   // Reference: classify each window site by its own GRBG colour
   function automatic void model(input int x, input int y, output int r, output int g, output int b);
      int gsum;
      gsum = 0;
      r = 0;
      b = 0;
      for (int dy = 0; dy < 2; dy++) begin
         for (int dx = 0; dx < 2; dx++) begin
            int px;
            int py;
            int v;
            px = x - 1 + dx;
            py = y - 1 + dy;
            v  = img[py][px];
            if ((px % 2) == 1 && (py % 2) == 0) r = v;
            else if ((px % 2) == 0 && (py % 2) == 1) b = v;
            else gsum = gsum + v;
         end
      end
      g = gsum >> 1;
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic pix(input int x, input int y, input int v, input bit use_model);
      int r;
      int g;
      int b;
      img[y][x] = v;
      iDATA = DATA_W'(v);
      iDVAL = 1'b1;
      if (use_model && x > 0 && y > 0) begin
         model(x, y, r, g, b);
         sb.push_back('{x: x, y: y, r: r, g: g, b: b, due: cyc + 2});
      end
      idle(1);
      iDVAL = 1'b0;
   endtask

   task automatic pix_hand(input int x, input int y, input int v, input int r, input int g, input int b);
      sb.push_back('{x: x, y: y, r: r, g: g, b: b, due: cyc + 2});
      pix(x, y, v, 1'b0);
   endtask

   task automatic frame(input int rows, input int base, input bit gaps, input int limit, input bit dval_after);
      int n;
      n = 0;
      iFVAL = 1'b1;
      idle(1);
      for (int y = 0; y < rows; y++) begin
         for (int x = 0; x < int'(LW); x++) begin
            if (n < limit) begin
               pix(x, y, base + 16 * y + x, 1'b1);
               n++;
               if (gaps) idle(1 + (n % 3));
            end
         end
      end
      iFVAL = 1'b0;
      iDVAL = dval_after;
      iDATA = 10'h3a5;
      idle(4);
      iDVAL = 1'b0;
   endtask

   // Monitor: every oDVAL must match the oldest expectation, on its due cycle
   always @(negedge iCLK) begin
      exp_t e;
      if (oDVAL) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dval cyc=%0d got R=%0d G=%0d B=%0d want no output",
                     cyc, oRed, oGreen, oBlue);
         end else begin
            e = sb.pop_front();
            if (int'(oRed) != e.r || int'(oGreen) != e.g || int'(oBlue) != e.b || cyc != e.due) begin
               errors++;
               $display("FAIL pix(%0d,%0d) got R=%0d G=%0d B=%0d cyc=%0d want R=%0d G=%0d B=%0d cyc=%0d",
                        e.x, e.y, oRed, oGreen, oBlue, cyc, e.r, e.g, e.b, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_dval pix(%0d,%0d) got none at cyc=%0d want R=%0d G=%0d B=%0d cyc=%0d",
                  e.x, e.y, cyc, e.r, e.g, e.b, e.due);
      end
   end

   initial begin
      int r;
      int g;
      int b;
      int wait_cnt;
      iRST_N = 1'b0;
      iFVAL  = 1'b0;
      iDVAL  = 1'b0;
      iDATA  = '0;
      idle(3);
      check("rst_dval",  int'(oDVAL),  0);
      check("rst_red",   int'(oRed),   0);
      check("rst_green", int'(oGreen), 0);
      check("rst_blue",  int'(oBlue),  0);
      iRST_N = 1'b1;
      idle(2);

      // Plain 4x4 frame, pixel = 16*y + x
      frame(4, 0, 1'b0, 16, 1'b0);
      model(3, 3, r, g, b);
      check("hold_red",   int'(oRed),   r);
      check("hold_green", int'(oGreen), g);
      check("hold_blue",  int'(oBlue),  b);

      // Green truncation at full scale
      iFVAL = 1'b1;
      idle(1);
      pix(0, 0, 1023, 1'b0);
      pix(1, 0, 5,    1'b0);
      pix(2, 0, 1023, 1'b0);
      pix(3, 0, 7,    1'b0);
      pix(0, 1, 8,    1'b0);
      pix_hand(1, 1, 1023, 5, 1023, 8);
      pix_hand(2, 1, 9,    5, 1023, 9);
      pix_hand(3, 1, 1022, 7, 1022, 9);
      iFVAL = 1'b0;
      idle(4);

      // Same frame with 1-3 idle cycles between pixels
      frame(4, 0, 1'b1, 16, 1'b0);

      // Frame cut after 6 pixels (iDVAL stays high), then a fresh frame
      frame(4, 100, 1'b0, 6, 1'b1);
      frame(4, 200, 1'b0, 16, 1'b0);

      // iDVAL while iFVAL low must be ignored
      iFVAL = 1'b0;
      for (int i = 0; i < 10; i++) begin
         iDVAL = 1'b1;
         iDATA = 10'($urandom);
         idle(1);
      end
      iDVAL = 1'b0;
      frame(2, 300, 1'b0, 8, 1'b0);

      // Asynchronous reset in the middle of a frame
      iFVAL = 1'b1;
      idle(1);
      for (int i = 0; i < 3; i++) pix(i, 0, int'(10'($urandom)), 1'b0);
      #2;
      iRST_N = 1'b0;
      #1;
      check("async_rst_dval",  int'(oDVAL),  0);
      check("async_rst_red",   int'(oRed),   0);
      check("async_rst_green", int'(oGreen), 0);
      check("async_rst_blue",  int'(oBlue),  0);
      idle(2);
      iRST_N = 1'b1;
      for (int i = 0; i < 6; i++) begin
         iDVAL = 1'b1;
         iDATA = 10'($urandom);
         idle(1);
      end
      iDVAL = 1'b0;
      iFVAL = 1'b0;
      idle(2);
      frame(4, 400, 1'b1, 16, 1'b0);

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         idle(1);
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
